// File: rtl/priv_1_12_csr_arbiter_if.sv
// Bundle between the two CSR requesters (core pipeline, debug module), the
// arbiter, and the single CSR-file access port.
interface priv_1_12_csr_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              core_req;
  logic [ADDR_W-1:0] core_addr;
  logic [1:0]        core_op;
  logic [DATA_W-1:0] core_wdata;
  logic [1:0]        core_priv;
  logic              core_flush;
  logic              core_ack;
  logic [DATA_W-1:0] core_rdata;
  logic              core_invalid;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [1:0]        dbg_op;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_invalid;

  logic              trap_inject;

  logic [ADDR_W-1:0] csr_addr;
  logic              csr_write;
  logic              csr_set;
  logic              csr_clear;
  logic [DATA_W-1:0] new_csr_val;
  logic              valid_write;
  logic [1:0]        curr_priv;
  logic [DATA_W-1:0] old_csr_val;
  logic              invalid_csr;
  logic              busy;

  // Arbiter side
  modport slave (
    input  core_req, core_addr, core_op, core_wdata, core_priv, core_flush,
    output core_ack, core_rdata, core_invalid,
    input  dbg_req, dbg_addr, dbg_op, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_invalid,
    input  trap_inject,
    output csr_addr, csr_write, csr_set, csr_clear, new_csr_val, valid_write, curr_priv,
    input  old_csr_val, invalid_csr,
    output busy
  );

  // Requester / CSR-file side
  modport master (
    output core_req, core_addr, core_op, core_wdata, core_priv, core_flush,
    input  core_ack, core_rdata, core_invalid,
    output dbg_req, dbg_addr, dbg_op, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_invalid,
    output trap_inject,
    input  csr_addr, csr_write, csr_set, csr_clear, new_csr_val, valid_write, curr_priv,
    output old_csr_val, invalid_csr,
    input  busy
  );
endinterface

// File: rtl/priv_1_12_csr_arbiter.sv
// Round-robin arbiter sharing the CSR-file port between core and debug;
// each access is READ, WRITE, RESP so requesters see atomic read-modify-write.
module priv_1_12_csr_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  priv_1_12_csr_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            r_state, w_next;
  logic              r_gnt_dbg;
  logic              r_last_dbg;
  logic              r_inv;
  logic [DATA_W-1:0] r_rdata;

  logic              w_core_req, w_grant, w_gnt_dbg, w_flush, w_active;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_op, w_priv;
  logic [DATA_W-1:0] w_wdata;

  assign w_core_req = bus.core_req & ~bus.core_flush;
  assign w_grant    = ~bus.trap_inject & (w_core_req | bus.dbg_req);
  // Debug wins only when core is absent or core was granted last.
  assign w_gnt_dbg  = bus.dbg_req & (~w_core_req | ~r_last_dbg);
  assign w_active   = (r_state == READ) || (r_state == WRITE);
  assign w_flush    = w_active & ~r_gnt_dbg & bus.core_flush;

  assign w_addr  = r_gnt_dbg ? bus.dbg_addr  : bus.core_addr;
  assign w_op    = r_gnt_dbg ? bus.dbg_op    : bus.core_op;
  assign w_wdata = r_gnt_dbg ? bus.dbg_wdata : bus.core_wdata;
  assign w_priv  = r_gnt_dbg ? 2'b11         : bus.core_priv;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_gnt_dbg  <= 1'b0;
      r_last_dbg <= 1'b1;
      r_inv      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant) r_gnt_dbg <= w_gnt_dbg;
      if (r_state == READ) begin
        r_rdata <= bus.old_csr_val;
        r_inv   <= bus.invalid_csr;
      end
      if (r_state == RESP || w_flush) r_last_dbg <= r_gnt_dbg;
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.csr_addr     = '0;
    bus.csr_write    = 1'b0;
    bus.csr_set      = 1'b0;
    bus.csr_clear    = 1'b0;
    bus.new_csr_val  = '0;
    bus.valid_write  = 1'b0;
    bus.curr_priv    = 2'b00;
    bus.core_ack     = 1'b0;
    bus.core_rdata   = '0;
    bus.core_invalid = 1'b0;
    bus.dbg_ack      = 1'b0;
    bus.dbg_rdata    = '0;
    bus.dbg_invalid  = 1'b0;
    bus.busy         = (r_state != IDLE);

    unique case (r_state)
      IDLE: if (w_grant) w_next = READ;
      READ, WRITE: begin
        bus.csr_addr  = w_addr;
        bus.curr_priv = w_priv;
        // A read is issued as set-with-zero so the CSR file still decodes access rights.
        unique case (w_op)
          2'b00: bus.csr_set = 1'b1;
          2'b01: begin bus.csr_write = 1'b1; bus.new_csr_val = w_wdata; end
          2'b10: begin bus.csr_set   = 1'b1; bus.new_csr_val = w_wdata; end
          default: begin bus.csr_clear = 1'b1; bus.new_csr_val = w_wdata; end
        endcase
        if (r_state == WRITE)
          bus.valid_write = ~((w_op == 2'b00) | r_inv | (w_op[1] & (w_wdata == '0))
                              | bus.trap_inject | w_flush);
        if (w_flush)                w_next = IDLE;
        else if (r_state == READ)   w_next = WRITE;
        else                        w_next = RESP;
      end
      RESP: begin
        if (r_gnt_dbg) begin
          bus.dbg_ack      = 1'b1;
          bus.dbg_rdata    = r_rdata;
          bus.dbg_invalid  = r_inv;
        end else begin
          bus.core_ack     = 1'b1;
          bus.core_rdata   = r_rdata;
          bus.core_invalid = r_inv;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_priv_1_12_csr_arbiter.sv
// Bench for priv_1_12_csr_arbiter: a small CSR-file model, table-driven
// accesses checked through an ack scoreboard, plus multi-cycle corner cases.
module tb_priv_1_12_csr_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  priv_1_12_csr_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();
  priv_1_12_csr_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus.slave)
  );

  // CSR file model: privilege field is addr[9:8]; commits on valid_write.
  logic [31:0] mem [0:4095];
  logic        mem_loaded = 1'b0;
  int          vw_cnt = 0;
  assign bus.old_csr_val = mem[bus.csr_addr];
  assign bus.invalid_csr = (bus.csr_addr[9:8] > bus.curr_priv);

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[12'h300] <= 32'h0000_1880;
      mem[12'h341] <= 32'h8000_0100;
      mem_loaded   <= 1'b1;
    end else if (bus.valid_write) begin
      vw_cnt <= vw_cnt + 1;
      if (bus.csr_write)      mem[bus.csr_addr] <= bus.new_csr_val;
      else if (bus.csr_set)   mem[bus.csr_addr] <= mem[bus.csr_addr] | bus.new_csr_val;
      else if (bus.csr_clear) mem[bus.csr_addr] <= mem[bus.csr_addr] & ~bus.new_csr_val;
    end
  end

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
    bit          inv;
  } exp_t;

  typedef struct {
    bit          dbg;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [1:0]  priv;
    logic [31:0] exp_rdata;
    bit          exp_inv;
    int          exp_vw;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected response.
  always @(negedge CLK) begin
    if (bus.core_ack && bus.dbg_ack) chk("ack_exclusive", 32'd1, 32'd0);
    if (bus.core_ack || bus.dbg_ack) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_who", {31'd0, bus.dbg_ack}, {31'd0, e.dbg});
        chk("rdata", e.dbg ? bus.dbg_rdata : bus.core_rdata, e.rdata);
        chk("invalid", {31'd0, e.dbg ? bus.dbg_invalid : bus.core_invalid}, {31'd0, e.inv});
      end
    end
  end

  task automatic set_core(input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] wd, input logic [1:0] pv);
    bus.core_addr = a; bus.core_op = op; bus.core_wdata = wd; bus.core_priv = pv;
  endtask

  task automatic set_dbg(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    bus.dbg_addr = a; bus.dbg_op = op; bus.dbg_wdata = wd;
  endtask

  task automatic do_access(input vec_t v);
    int lat, vw0;
    @(negedge CLK);
    vw0 = vw_cnt;
    if (v.dbg) begin set_dbg(v.addr, v.op, v.wdata); bus.dbg_req = 1'b1; end
    else begin set_core(v.addr, v.op, v.wdata, v.priv); bus.core_req = 1'b1; end
    sb.push_back('{v.dbg, v.exp_rdata, v.exp_inv});
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge CLK);
      if (v.dbg ? bus.dbg_ack : bus.core_ack) lat = i;
    end
    bus.core_req = 1'b0;
    bus.dbg_req  = 1'b0;
    chk("latency", 32'(lat), 32'd3);
    chk("vw_count", 32'(vw_cnt - vw0), 32'(v.exp_vw));
  endtask

  vec_t vecs[11];
  int   ack_cyc[3];
  int   n_ack, vw0, lat;
  bit   busy_seen;

  initial begin
    vecs[0]  = '{0, 12'h340, 2'b01, 32'hDEADBEEF, 2'b11, 32'h0000_0000, 0, 1};
    vecs[1]  = '{0, 12'h340, 2'b00, 32'h0000_0000, 2'b11, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{0, 12'h300, 2'b10, 32'h0000_0000, 2'b11, 32'h0000_1880, 0, 0};
    vecs[3]  = '{0, 12'h300, 2'b01, 32'h1234_5678, 2'b00, 32'h0000_1880, 1, 0};
    vecs[4]  = '{0, 12'h300, 2'b00, 32'h0000_0000, 2'b11, 32'h0000_1880, 0, 0};
    vecs[5]  = '{1, 12'h340, 2'b10, 32'h0000_00F0, 2'b00, 32'hDEADBEEF, 0, 1};
    vecs[6]  = '{1, 12'h340, 2'b11, 32'h0000_000F, 2'b00, 32'hDEADBEFF, 0, 1};
    vecs[7]  = '{1, 12'h340, 2'b00, 32'h0000_0000, 2'b00, 32'hDEADBEF0, 0, 0};
    vecs[8]  = '{0, 12'h140, 2'b01, 32'h0000_00A5, 2'b01, 32'h0000_0000, 0, 1};
    vecs[9]  = '{0, 12'h140, 2'b00, 32'h0000_0000, 2'b00, 32'h0000_00A5, 1, 0};
    vecs[10] = '{1, 12'h300, 2'b11, 32'h0000_0000, 2'b00, 32'h0000_1880, 0, 0};

    bus.core_req = 0; bus.core_flush = 0; bus.dbg_req = 0; bus.trap_inject = 0;
    set_core('0, 2'b00, '0, 2'b11);
    set_dbg('0, 2'b00, '0);

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_acks", {30'd0, bus.core_ack, bus.dbg_ack}, 32'd0);
    chk("rst_csr_flags", {28'd0, bus.csr_write, bus.csr_set, bus.csr_clear, bus.valid_write}, 32'd0);
    nRST = 1'b1;

    // Round-robin from reset with both requesters held: core, debug, core
    @(negedge CLK);
    set_core(12'h340, 2'b00, '0, 2'b11);
    set_dbg(12'h341, 2'b00, '0);
    bus.core_req = 1; bus.dbg_req = 1;
    sb.push_back('{0, 32'h0, 0});
    sb.push_back('{1, 32'h8000_0100, 0});
    sb.push_back('{0, 32'h0, 0});
    n_ack = 0;
    for (int c = 1; c <= 14 && n_ack < 3; c++) begin
      @(negedge CLK);
      if (bus.core_ack || bus.dbg_ack) begin
        ack_cyc[n_ack] = c;
        n_ack++;
        if (bus.dbg_ack) bus.dbg_req = 0;
      end
    end
    bus.core_req = 0; bus.dbg_req = 0;
    chk("rr_ack_count", 32'(n_ack), 32'd3);
    chk("rr_ack0_cycle", 32'(ack_cyc[0]), 32'd3);
    chk("rr_ack1_cycle", 32'(ack_cyc[1]), 32'd7);
    chk("rr_ack2_cycle", 32'(ack_cyc[2]), 32'd11);

    for (int unsigned k = 0; k < 11; k++) do_access(vecs[k]);

    // Flush during WRITE of a core write to mepc, debug read waiting
    @(negedge CLK);
    vw0 = vw_cnt;
    set_core(12'h341, 2'b01, 32'h0000_1234, 2'b11);
    bus.core_req = 1;
    @(negedge CLK);
    set_dbg(12'h341, 2'b00, '0);
    bus.dbg_req = 1;
    sb.push_back('{1, 32'h8000_0100, 0});
    @(negedge CLK);
    bus.core_flush = 1;
    #1 chk("flush_vw", {31'd0, bus.valid_write}, 32'd0);
    @(negedge CLK);
    bus.core_flush = 0; bus.core_req = 0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_vw_cnt", 32'(vw_cnt - vw0), 32'd0);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge CLK);
      if (bus.dbg_ack) lat = i;
    end
    bus.dbg_req = 0;
    chk("flush_dbg_latency", 32'(lat), 32'd3);

    // trap_inject blocks grants in IDLE
    @(negedge CLK);
    bus.trap_inject = 1;
    set_dbg(12'h340, 2'b00, '0);
    bus.dbg_req = 1;
    busy_seen = 0;
    repeat (5) begin
      @(negedge CLK);
      busy_seen |= bus.busy;
    end
    chk("trap_hold_busy", {31'd0, busy_seen}, 32'd0);
    bus.trap_inject = 0;
    sb.push_back('{1, 32'hDEADBEF0, 0});
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge CLK);
      if (bus.dbg_ack) lat = i;
    end
    bus.dbg_req = 0;
    chk("trap_release_latency", 32'(lat), 32'd3);

    // trap_inject during WRITE suppresses the commit but the access still acks
    @(negedge CLK);
    vw0 = vw_cnt;
    set_core(12'h340, 2'b01, 32'h1111_1111, 2'b11);
    bus.core_req = 1;
    sb.push_back('{0, 32'hDEADBEF0, 0});
    @(negedge CLK);
    @(negedge CLK);
    bus.trap_inject = 1;
    #1 chk("trap_write_vw", {31'd0, bus.valid_write}, 32'd0);
    @(negedge CLK);
    bus.trap_inject = 0;
    chk("trap_write_ack", {31'd0, bus.core_ack}, 32'd1);
    bus.core_req = 0;
    chk("trap_write_vw_cnt", 32'(vw_cnt - vw0), 32'd0);
    do_access('{0, 12'h340, 2'b00, 32'h0, 2'b11, 32'hDEADBEF0, 0, 0});

    // Reset asserted in WRITE clears outputs at once
    @(negedge CLK);
    set_core(12'h340, 2'b01, 32'h2222_2222, 2'b11);
    bus.core_req = 1;
    @(negedge CLK);
    @(negedge CLK);
    #1 chk("pre_reset_vw", {31'd0, bus.valid_write}, 32'd1);
    nRST = 0;
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_vw", {31'd0, bus.valid_write}, 32'd0);
    chk("reset_csr_write", {31'd0, bus.csr_write}, 32'd0);
    chk("reset_csr_addr", {20'd0, bus.csr_addr}, 32'd0);
    bus.core_req = 0;
    @(negedge CLK);
    nRST = 1;
    do_access('{0, 12'h340, 2'b00, 32'h0, 2'b11, 32'hDEADBEF0, 0, 0});

    repeat (2) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
